tt_serial_subtractor: RTL and testbench
=======================================

# tt_serial_subtractor

- Bit-serial WIDTH-bit unsigned subtractor computing `diff = a - b` one bit per clock, LSB first, with a single borrow flip-flop.
- Inverse-operation companion to the team's 8-bit adder tile; sits behind the same pin wrapper.
- Trades latency for area: one 1-bit full-subtractor cell plus shift registers instead of a parallel borrow chain.
- Uses a start/ready/done handshake; results are held until the next operation completes.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a subtraction; accepted only while ready=1
- a  in  WIDTH  minuend, sampled on the accepting edge only
- b  in  WIDTH  subtrahend, sampled on the accepting edge only
- ready  out  1  high in IDLE
- busy  out  1  high in SHIFT
- done  out  1  one-cycle pulse, high in DONE
- diff  out  WIDTH  registered result, (a - b) mod 2^WIDTH
- borrow  out  1  registered borrow-out; 1 iff a < b unsigned
- zero  out  1  registered flag; 1 iff diff == 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start=1:
  - load the A shift register from a and the B shift register from b;
  - clear the borrow flop and the bit counter.
- SHIFT, each cycle:
  - d = A[0] ^ B[0] ^ bw;
  - bw_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & bw);
  - shift A and B right by 1;
  - shift d into the MSB of the internal result register R;
  - increment the counter.
- SHIFT → DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1). On that same edge:
  - diff ← final R (including that bit);
  - borrow ← final bw_next;
  - zero ← (final R == 0).
- DONE → IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE. No queuing; a request must be re-presented once ready=1.
- diff, borrow and zero change only on the SHIFT → DONE edge. They hold across IDLE and across subsequent SHIFT cycles.
- Arithmetic is modulo 2^WIDTH. No signed interpretation; borrow is the only overflow indicator.
- Reset (any time, including mid-SHIFT):
  - state IDLE, so ready=1, busy=0, done=0;
  - diff=0, borrow=0, zero=0;
  - shift registers, counter and borrow flop all 0;
  - an aborted operation never produces done.

## Timing
- start=1 sampled at edge N: busy=1 from edge N through edge N+WIDTH.
- Bits 0..WIDTH-1 are processed at edges N+1..N+WIDTH.
- done=1 and the new results are visible in the cycle after edge N+WIDTH. Latency is WIDTH edges from acceptance to done.
- ready=1 again after edge N+WIDTH+1. Issue interval is WIDTH+2 cycles.
- start held high continuously: the next operation is accepted at edge N+WIDTH+2, using a and b as sampled at that edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `tt_arith_pkg`:
  - FSM state enum (IDLE, SHIFT, DONE);
  - default WIDTH constant;
  - counter width, computed as $clog2(WIDTH).
- Sub-module `full_subtractor` (1-bit, combinational: a, b, bin → d, bout), instantiated once.
- Everything else lives in the top module: FSM, counter, A/B/R shift registers, borrow flop, output registers.

## Test plan
- Reset release, no start → ready=1, busy=0, done=0, diff=0x00, borrow=0, zero=0.
- a=0x91 (145), b=0x37 (55), start for 1 cycle:
  - done exactly 8 edges after acceptance;
  - diff=0x5A, borrow=0, zero=0;
  - outputs hold afterwards.
- a=0x10, b=0x20 → diff=0xF0, borrow=1, zero=0.
- a=0x00, b=0xFF → diff=0x01, borrow=1.
- a=0x5A, b=0x5A → diff=0x00, borrow=0, zero=1.
- start pulsed mid-SHIFT with different operands → ignored; first result is unchanged, and only one done pulse occurs.
- Reset asserted at bit 4 of an operation → immediate IDLE with all outputs 0, and no done pulse.
- start held high with a=0x03, b=0x01 → successive done pulses 10 cycles apart, each with diff=0x02.

Source files
------------

// File: rtl/tt_serial_subtractor_pkg.sv
// tt_arith_pkg: shared FSM state type and sizing constants for the serial arithmetic tiles
//   DEF_WIDTH  default operand width
//   DEF_CNT_W  bit-counter width for the default operand width
package tt_arith_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/tt_serial_subtractor_if.sv
// tt_serial_subtractor_if: start/ready/done handshake and result bus of the serial subtractor
//   master drives start, a, b; slave drives ready, busy, done, diff, borrow, zero
interface tt_serial_subtractor_if #(parameter int WIDTH = tt_arith_pkg::DEF_WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ready;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow;
  logic zero;
  modport master(output start, a, b, input ready, busy, done, diff, borrow, zero);
  modport slave(input start, a, b, output ready, busy, done, diff, borrow, zero);
endinterface

// File: rtl/tt_serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit combinational full subtractor
//   i_a - i_b - i_bin -> o_d with borrow-out o_bout
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/tt_serial_subtractor.sv
// tt_serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first
//   clk, rst (async, active-high); s: slave side of tt_serial_subtractor_if
module tt_serial_subtractor
  import tt_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  tt_serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_r, r_diff, w_r;
  logic [CW-1:0] r_cnt;
  logic r_bw, r_borrow, r_zero, w_d, w_bout, w_last;
  full_subtractor u_fs (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_bw),
    .o_d   (w_d),
    .o_bout(w_bout)
  );
  assign w_r    = {w_d, r_r[WIDTH-1:1]};
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s.start ? SHIFT : IDLE;
      SHIFT:   w_next = w_last ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_bw     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && s.start) begin
        r_a   <= s.a;
        r_b   <= s.b;
        r_bw  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_r   <= w_r;
        r_bw  <= w_bout;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff   <= w_r;
          r_borrow <= w_bout;
          r_zero   <= w_r == '0;
        end
      end
    end
  end
  assign s.ready  = r_state == IDLE;
  assign s.busy   = r_state == SHIFT;
  assign s.done   = r_state == DONE;
  assign s.diff   = r_diff;
  assign s.borrow = r_borrow;
  assign s.zero   = r_zero;
endmodule

// File: tb/tb_tt_serial_subtractor.sv
// tb_tt_serial_subtractor: scoreboard bench for tt_serial_subtractor with directed vectors
module tb_tt_serial_subtractor;
  typedef struct {
    logic [7:0] d;
    logic bw;
    logic z;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  tt_serial_subtractor_if #(.WIDTH(8)) bus ();
  tt_serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", {24'd0, bus.diff}, {24'd0, e.d});
        chk("borrow", {31'd0, bus.borrow}, {31'd0, e.bw});
        chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
        chk("latency", cyc, e.cyc);
      end
    end
  end
  task automatic wait_ready();
    for (int i = 0; i < 40 && !bus.ready; i++) @(negedge clk);
    if (!bus.ready) chk("ready_timeout", 0, 1);
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push,
                       input logic [7:0] d, input logic bw, input logic z);
    exp_t e;
    wait_ready();
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e.d = d;
    e.bw = bw;
    e.z = z;
    e.cyc = cyc + 8;
    if (push) q.push_back(e);
  endtask
  initial begin
    int k0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
    chk("rst_zero", bus.zero, 0);
    issue(8'h91, 8'h37, 1, 8'h5A, 0, 0);
    chk("busy_after_accept", bus.busy, 1);
    repeat (14) @(negedge clk);
    chk("hold_diff", bus.diff, 8'h5A);
    chk("hold_ready", bus.ready, 1);
    chk("hold_done", bus.done, 0);
    issue(8'h10, 8'h20, 1, 8'hF0, 1, 0);
    issue(8'h00, 8'hFF, 1, 8'h01, 1, 0);
    issue(8'h5A, 8'h5A, 1, 8'h00, 0, 1);
    issue(8'h44, 8'h11, 1, 8'h33, 0, 0);
    repeat (2) @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored_start_diff", bus.diff, 8'h33);
    issue(8'h22, 8'h11, 0, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_diff", bus.diff, 0);
    chk("abort_borrow", bus.borrow, 0);
    chk("abort_zero", bus.zero, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    wait_ready();
    bus.a = 8'h03;
    bus.b = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    k0 = cyc;
    for (int i = 0; i < 3; i++) q.push_back('{d: 8'h02, bw: 1'b0, z: 1'b0, cyc: k0 + 8 + 10 * i});
    while (cyc < k0 + 20) @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
